alarm_system_sensor_pio: RTL and testbench
==========================================

// Module: alarm_system_sensor_pio
// PURPOSE
//  Avalon-MM slave input port, the read-side counterpart of the ALARM output PIO.
//  Samples WIDTH asynchronous sensor pins (door/PIR/button), synchronises and debounces
//  them, latches qualifying edges in a W1C edge-capture register, and raises a
//  level-sensitive irq to the Nios II. Sits on the same system interconnect as ALARM.
// PARAMETERS
//  WIDTH            4   number of sensor pins (1..32)
//  DEBOUNCE_CYCLES  16  clocks a synced bit must differ from its stable value before
//                       it is accepted (>=1; 1 = accept on first differing sample)
//  EDGE_TYPE        0   0 = rising, 1 = falling, 2 = any edge sets edgecapture
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      asynchronous reset, active low
//  address     in   2      register select
//  chipselect  in   1      slave select
//  write_n     in   1      write strobe, active low
//  writedata   in   32     write data
//  in_port     in   WIDTH  raw asynchronous sensor pins
//  readdata    out  32     read data, zero-wait-state, combinational from registers
//  irq         out  1      |(edgecapture & irqmask)
// BEHAVIOUR
//  Reset (async, reset_n=0): sync stages, stable, stable_q, debounce counters,
//   irqmask, edgecapture all 0 -> readdata=0 (for any address), irq=0.
//  Register map (readdata bits above WIDTH are 0):
//   0 data        RO  debounced stable value; writes ignored
//   1 reserved    RO  reads 0; writes ignored
//   2 irqmask     RW  [WIDTH-1:0] bit enables irq contribution of that edgecapture bit
//   3 edgecapture W1C writing 1 to bit i clears bit i; writing 0 leaves it
//  Write accepted when chipselect && !write_n, takes effect on that clk edge.
//  Pipeline per bit: 2-flop synchroniser -> debounce -> stable -> stable_q.
//  Debounce: if sync != stable, cnt++; when cnt == DEBOUNCE_CYCLES-1 and still
//   differs, stable <= sync, cnt <= 0. If sync == stable, cnt <= 0 (glitch rejected).
//   cnt width = $clog2(DEBOUNCE_CYCLES+1); counter must never wrap.
//  Latency: pin change to data register = 2 + DEBOUNCE_CYCLES clocks; to
//   edgecapture/irq = one further clock.
//  Edge detect: rise = stable & ~stable_q, fall = ~stable & stable_q, per EDGE_TYPE.
//  Edgecapture bit sets on detected edge and stays set until W1C.
//  Simultaneous W1C and new edge on same bit in same cycle: set wins.
//  irqmask change takes effect on irq the cycle after the write; clearing mask does
//   not clear edgecapture.
//  Pins high at reset release: stable rises after debounce -> rising edge captured;
//   this is intended (firmware clears edgecapture at init).
//  Reset mid-debounce: counter discarded, no partial-state carry-over.
// STRUCTURE
//  Package alarm_system_pio_pkg: register address constants (ADDR_DATA=0,
//   ADDR_IRQMASK=2, ADDR_EDGECAP=3), EDGE_RISE/EDGE_FALL/EDGE_ANY encodings.
//  Sub-module alarm_system_debounce: one bit, synchroniser + counter + stable
//   output; instantiated WIDTH times with a generate loop. Top holds edge detect,
//   registers, read mux, irq.
// TESTING (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=0 unless stated)
//  1 Reset: assert reset_n=0 mid-run -> readdata=0 at all addresses, irq=0 at once.
//  2 in_port 0->4'b0010 held -> data reads 2 after exactly 6 clocks, edgecapture=2
//    after 7; irqmask=0 so irq stays 0; write irqmask=2 -> irq=1 next clock.
//  3 Glitch: bit0 high for 3 clocks then low -> data stays 0, edgecapture stays 0.
//  4 W1C: edgecapture=4'b0110, write 4'b0010 to addr 3 -> reads 4'b0100; irq drops
//    only when no masked bit remains set.
//  5 Collision: W1C of bit1 in same cycle bit1 edge is detected -> bit1 remains 1.
//  6 EDGE_TYPE=2: bit3 0->1->0 (each held 10 clocks), clear between -> captured both.

Source files
------------

// File: rtl/alarm_system_pio_pkg.sv
// alarm_system_pio_pkg: register map and edge-type encodings for the sensor input PIO
package alarm_system_pio_pkg;
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/alarm_system_debounce.sv
// alarm_system_debounce: one sensor bit, 2-flop synchroniser followed by a debounce counter
module alarm_system_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2;
  logic [CW-1:0] cnt;
  // counter restarts whenever the synced bit agrees with stable, so it never wraps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == stable) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= s2;
        cnt    <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alarm_system_sensor_pio.sv
// alarm_system_sensor_pio: Avalon-MM input PIO with debounced pins, W1C edge capture and irq
module alarm_system_sensor_pio
  import alarm_system_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] stable, stable_q, irqmask, edgecapture, edge_det, w1c, rd_sel;
  logic wr, unused_wd;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    alarm_system_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
      .stable (stable[i])
    );
  end
  assign wr        = chipselect & ~write_n;
  assign unused_wd = ^writedata;
  always_comb begin
    edge_det = EDGE_TYPE == EDGE_FALL ? ~stable & stable_q :
               EDGE_TYPE == EDGE_ANY  ? stable ^ stable_q : stable & ~stable_q;
    w1c      = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    rd_sel   = address == ADDR_DATA    ? stable :
               address == ADDR_IRQMASK ? irqmask :
               address == ADDR_EDGECAP ? edgecapture : '0;
  end
  // a new edge is OR-ed in after the clear so it wins over a same-cycle W1C
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q    <= '0;
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      stable_q    <= stable;
      edgecapture <= (edgecapture & ~w1c) | edge_det;
      if (wr && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
    end
  end
  assign readdata = 32'(rd_sel);
  assign irq      = |(edgecapture & irqmask);
endmodule

// File: tb/tb_alarm_system_sensor_pio.sv
// tb_alarm_system_sensor_pio: scoreboard bench, rising-edge and any-edge instances driven in parallel
module tb_alarm_system_sensor_pio;
  localparam int W = 4;
  localparam int D = 4;
  logic clk = 1'b0, reset_n = 1'b0, chipselect = 1'b0, write_n = 1'b1;
  logic [1:0] address = 2'd0;
  logic [31:0] writedata = 32'd0;
  logic [W-1:0] in_port = '0;
  logic [31:0] rd0, rd2;
  logic irq0, irq2;
  always #5 clk = ~clk;
  alarm_system_sensor_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd0), .irq(irq0));
  alarm_system_sensor_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd2), .irq(irq2));
  typedef struct packed {
    logic [31:0] rd0;
    logic [31:0] rd2;
    logic        irq0;
    logic        irq2;
  } exp_t;
  exp_t sb[$];
  int n_vec = 0, n_err = 0;
  event sample;
  // reference: history of applied pin values; a bit is accepted once the synced
  // view (pins delayed two clocks) has shown the opposite level for D samples in a row
  logic [W-1:0] hist[$];
  logic [W-1:0] m_stable, m_prev, m_mask;
  logic [W-1:0] m_ec[2];
  logic [W-1:0] pins = '0;
  function automatic logic [31:0] rd_model(int e, logic [1:0] a);
    return a == 2'd0 ? 32'(m_stable) : a == 2'd2 ? 32'(m_mask) : a == 2'd3 ? 32'(m_ec[e]) : 32'd0;
  endfunction
  task automatic push_exp();
    exp_t x;
    x.rd0  = rd_model(0, address);
    x.rd2  = rd_model(1, address);
    x.irq0 = |(m_ec[0] & m_mask);
    x.irq2 = |(m_ec[1] & m_mask);
    sb.push_back(x);
  endtask
  task automatic model_reset();
    m_stable = '0; m_prev = '0; m_mask = '0; m_ec[0] = '0; m_ec[1] = '0;
    hist.delete();
    repeat (D + 2) hist.push_back('0);
  endtask
  task automatic model_edge();
    logic [W-1:0] ns, clr, rise, fall;
    bit ok;
    hist.push_front(in_port);
    void'(hist.pop_back());
    ns = m_stable;
    for (int b = 0; b < W; b++) begin
      ok = 1'b1;
      for (int j = 2; j <= D + 1; j++) if (hist[j][b] == m_stable[b]) ok = 1'b0;
      if (ok) ns[b] = ~m_stable[b];
    end
    rise = m_stable & ~m_prev;
    fall = ~m_stable & m_prev;
    clr  = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
    m_ec[0] = (m_ec[0] & ~clr) | rise;
    m_ec[1] = (m_ec[1] & ~clr) | rise | fall;
    if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
    m_prev   = m_stable;
    m_stable = ns;
  endtask
  task automatic cycle(input logic rn, input logic [W-1:0] p, input logic cs, input logic wn,
                       input logic [1:0] a, input logic [31:0] wd);
    @(negedge clk);
    #1;
    reset_n = rn; in_port = p; chipselect = cs; write_n = wn; address = a; writedata = wd;
    if (!rn) begin
      model_reset();
      #1 push_exp();
      ->sample;
    end
    @(posedge clk);
    if (rn) model_edge();
    #1 push_exp();
  endtask
  task automatic rd(input logic [1:0] a);
    cycle(1'b1, pins, 1'b0, 1'b1, a, 32'd0);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cycle(1'b1, pins, 1'b1, 1'b0, a, d);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  initial begin
    exp_t x;
    forever begin
      @(negedge clk or sample);
      while (sb.size() > 0) begin
        x = sb.pop_front();
        chk("readdata_rise", rd0, x.rd0);
        chk("readdata_any", rd2, x.rd2);
        chk("irq_rise", 32'(irq0), 32'(x.irq0));
        chk("irq_any", 32'(irq2), 32'(x.irq2));
      end
    end
  end
  initial begin
    model_reset();
    for (int a = 0; a < 4; a++) cycle(1'b0, '0, 1'b0, 1'b1, 2'(a), 32'd0);
    pins = 4'b0010;
    for (int i = 0; i < 8; i++) rd(i < 6 ? 2'd0 : 2'd3);
    wr(2'd2, 32'h2);
    rd(2'd3);
    rd(2'd0);
    pins = 4'b0011;
    repeat (3) rd(2'd0);
    pins = 4'b0010;
    for (int i = 0; i < 10; i++) rd(2'(i % 2 == 0 ? 0 : 3));
    pins = 4'b0000;
    repeat (8) rd(2'd3);
    pins = 4'b0010;
    repeat (6) rd(2'd0);
    wr(2'd3, 32'h2);
    repeat (3) rd(2'd3);
    pins = 4'b0110;
    repeat (8) rd(2'd3);
    wr(2'd3, 32'h2);
    rd(2'd3);
    wr(2'd2, 32'h4);
    rd(2'd3);
    wr(2'd3, 32'h4);
    rd(2'd3);
    wr(2'd3, 32'hF);
    pins = 4'b1000;
    repeat (10) rd(2'd3);
    wr(2'd3, 32'hF);
    pins = 4'b0000;
    repeat (10) rd(2'd3);
    wr(2'd2, 32'hF);
    pins = 4'b1010;
    repeat (4) rd(2'd3);
    for (int a = 0; a < 4; a++) cycle(1'b0, pins, 1'b0, 1'b1, 2'(a), 32'd0);
    repeat (12) rd(2'd3);
    for (int i = 0; i < 900; i++) begin
      logic rn;
      if ($urandom_range(0, 5) == 0) pins ^= 4'($urandom);
      rn = $urandom_range(0, 299) != 0;
      cycle(rn, pins, 1'($urandom), $urandom_range(0, 3) != 0, 2'($urandom), $urandom);
    end
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
